// File: rtl/systolic_ctrl.sv
// systolic_ctrl: runs clear/feed/wait/drain for a ROWS x COLS systolic array and streams registered PE results.
// Define SYSTOLIC_CTRL_WATCHDOG_EN to add a WAIT-state timeout that raises a sticky err.
module systolic_ctrl #(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    parameter int VECTOR_LENGTH = 4,
    parameter int ACC_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int IW = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           array_clear,
    output logic [ROWS-1:0]                a_row_valid,
    output logic [ROWS*IW-1:0]             a_row_idx,
    output logic [COLS-1:0]                b_col_valid,
    output logic [COLS*IW-1:0]             b_col_idx,
    input  logic [ROWS*COLS-1:0]           acc_valid_in,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_in,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [ACC_WIDTH-1:0]           res_data,
    output logic [RW-1:0]                  res_row,
    output logic [CW-1:0]                  res_col,
    output logic                           err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam int FEED_LAST = VECTOR_LENGTH + ((ROWS > COLS) ? ROWS : COLS) - 2;
    localparam int TW = $clog2(FEED_LAST + 2);

    logic [2:0]           r_state, w_next;
    logic [TW-1:0]        r_t;
    logic [RW-1:0]        r_row;
    logic [CW-1:0]        r_col;
    logic [ACC_WIDTH-1:0] r_res [ROWS][COLS];
    logic                 w_all_valid, w_fire, w_col_last, w_last, w_timeout;

    assign w_all_valid = &acc_valid_in;
    assign res_valid   = r_state == S_DRAIN;
    assign w_fire      = res_valid & res_ready;
    assign w_col_last  = r_col == CW'(COLS - 1);
    assign w_last      = w_col_last && r_row == RW'(ROWS - 1);
    assign busy        = r_state != S_IDLE;
    assign done        = r_state == S_DONE;
    assign array_clear = r_state == S_CLEAR;
    assign res_row     = r_row;
    assign res_col     = r_col;
    assign res_data    = res_valid ? r_res[r_row][r_col] : '0;

    assign w_next = (r_state == S_IDLE)  ? (start ? S_CLEAR : S_IDLE) :
                    (r_state == S_CLEAR) ? S_FEED :
                    (r_state == S_FEED)  ? ((r_t == TW'(FEED_LAST)) ? S_WAIT : S_FEED) :
                    (r_state == S_WAIT)  ? (w_all_valid ? S_DRAIN : w_timeout ? S_DONE : S_WAIT) :
                    (r_state == S_DRAIN) ? ((w_fire && w_last) ? S_DONE : S_DRAIN) : S_IDLE;

    // Skewed edge feed: row r / column c sees element k at feed step t = r + k / c + k.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign a_row_valid[r] = r_state == S_FEED && r_t >= TW'(r) && r_t < TW'(r + VECTOR_LENGTH);
        assign a_row_idx[r*IW +: IW] = a_row_valid[r] ? IW'(r_t - TW'(r)) : '0;
    end
    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign b_col_valid[c] = r_state == S_FEED && r_t >= TW'(c) && r_t < TW'(c + VECTOR_LENGTH);
        assign b_col_idx[c*IW +: IW] = b_col_valid[c] ? IW'(r_t - TW'(c)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_next;
            r_t     <= (r_state == S_FEED) ? r_t + TW'(1) : '0;
            if (w_fire) begin
                r_col <= w_col_last ? '0 : r_col + CW'(1);
                r_row <= w_last ? '0 : w_col_last ? r_row + RW'(1) : r_row;
            end
        end
    end

    // Snapshot every accumulator on the WAIT->DRAIN edge so the drain never depends on live PE outputs.
    always_ff @(posedge clk) begin
        if (r_state == S_WAIT && w_all_valid)
            for (int i = 0; i < ROWS * COLS; i++)
                r_res[i / COLS][i % COLS] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
    end

`ifdef SYSTOLIC_CTRL_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] r_wcnt;
    logic          r_err;

    assign w_timeout = r_state == S_WAIT && !w_all_valid && r_wcnt == WW'(TIMEOUT_CYCLES - 1);
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wcnt <= (r_state == S_WAIT) ? r_wcnt + WW'(1) : '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    // No watchdog: err is constant low for any legal TIMEOUT_CYCLES.
    assign err = (TIMEOUT_CYCLES < 1) & 1'b0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: drives systolic_ctrl against a behavioural 2x2 PE array and scoreboards the result stream.
module tb_systolic_ctrl;
    localparam int R = 2, C = 2, VL = 4, AW = 16, TO = 64, FEED_N = VL + ((R > C) ? R : C) - 1;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
    logic busy, done, array_clear, res_valid, err;
    logic [R-1:0] a_row_valid;
    logic [R*2-1:0] a_row_idx;
    logic [C-1:0] b_col_valid;
    logic [C*2-1:0] b_col_idx;
    logic [R*C-1:0] acc_valid_in;
    logic [R*C*AW-1:0] acc_in;
    logic [AW-1:0] res_data;
    logic [0:0] res_row, res_col;
    int n_cmp = 0, n_bad = 0, done_cnt = 0;

    typedef struct { int row; int col; logic [15:0] data; } exp_t;
    exp_t q[$];

    logic signed [15:0] am [R][VL];
    logic signed [15:0] bm [VL][C];
    logic av [R][C], bv [R][C];
    logic [1:0] ai [R][C], bi [R][C];
    logic signed [15:0] acc [R][C];
    int cnt [R][C];
    logic [R*C-1:0] vmask = '1;
    logic misalign = 1'b0;

    always #5 clk = ~clk;

    systolic_ctrl #(.ROWS(R), .COLS(C), .VECTOR_LENGTH(VL), .ACC_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .array_clear(array_clear),
        .a_row_valid(a_row_valid), .a_row_idx(a_row_idx), .b_col_valid(b_col_valid), .b_col_idx(b_col_idx),
        .acc_valid_in(acc_valid_in), .acc_in(acc_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_row(res_row), .res_col(res_col), .err(err)
    );

    function automatic logic signed [15:0] q15(input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        return p[30:15];
    endfunction

    function automatic logic [15:0] dot(input int r, input int c);
        logic signed [15:0] s;
        s = '0;
        for (int k = 0; k < VL; k++) s = s + q15(am[r][k], bm[k][c]);
        return s;
    endfunction

    // Systolic array model: a moves right one PE per cycle, b moves down one PE per cycle.
    always @(posedge clk) begin
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                if (rst) begin
                    av[r][c] <= 1'b0; bv[r][c] <= 1'b0; ai[r][c] <= '0; bi[r][c] <= '0;
                    acc[r][c] <= '0; cnt[r][c] <= 0;
                end else begin
                    if (c == 0) begin av[r][c] <= a_row_valid[r]; ai[r][c] <= a_row_idx[r*2 +: 2]; end
                    else begin av[r][c] <= av[r][c-1]; ai[r][c] <= ai[r][c-1]; end
                    if (r == 0) begin bv[r][c] <= b_col_valid[c]; bi[r][c] <= b_col_idx[c*2 +: 2]; end
                    else begin bv[r][c] <= bv[r-1][c]; bi[r][c] <= bi[r-1][c]; end
                    if (array_clear) begin
                        acc[r][c] <= '0; cnt[r][c] <= 0;
                    end else if (av[r][c] && bv[r][c]) begin
                        acc[r][c] <= acc[r][c] + q15(am[r][ai[r][c]], bm[bi[r][c]][c]);
                        cnt[r][c] <= cnt[r][c] + 1;
                        if (ai[r][c] !== bi[r][c]) misalign <= 1'b1;
                    end
                end
            end
    end

    always_comb begin
        acc_valid_in = '0;
        acc_in = '0;
        for (int i = 0; i < R * C; i++) begin
            acc_valid_in[i] = (cnt[i / C][i % C] == VL) && vmask[i];
            acc_in[i*AW +: AW] = acc[i / C][i % C];
        end
    end

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic load_random();
        for (int r = 0; r < R; r++) for (int k = 0; k < VL; k++) am[r][k] = 16'($urandom);
        for (int k = 0; k < VL; k++) for (int c = 0; c < C; c++) bm[k][c] = 16'($urandom);
    endtask

    task automatic push_expected();
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) q.push_back('{r, c, dot(r, c)});
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // mode 0: always ready, 1: three-cycle stall on the second result, 2: random ready
    task automatic test_drain(input int mode, input bit start_in_done);
        int cyc, stalls, got, d0;
        cyc = 0; stalls = 0; got = 0; d0 = done_cnt;
        while (q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            res_ready = (mode == 1) ? !(got == 1 && stalls < 3) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (res_valid) begin
                n_cmp++;
                if ({res_row, res_col, res_data} !== {1'(q[0].row), 1'(q[0].col), q[0].data}) begin
                    n_bad++;
                    $display("FAIL result: got row=%0d col=%0d data=%0d, want row=%0d col=%0d data=%0d",
                             res_row, res_col, res_data, q[0].row, q[0].col, q[0].data);
                end
                if (!res_ready) stalls++;
                else begin void'(q.pop_front()); got++; end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL drain_timeout: %0d results left, want 0", q.size()); q.delete(); end
        @(negedge clk);
        res_ready = 1'b0;
        start = start_in_done;
        n_cmp++;
        if ({done, res_valid} !== 2'b10) begin
            n_bad++; $display("FAIL done_pulse: done=%b res_valid=%b, want 1 0", done, res_valid);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({done, busy, array_clear} !== 3'b000) begin
            n_bad++; $display("FAIL after_done: done/busy/clear=%b, want 000", {done, busy, array_clear});
        end
        n_cmp++;
        if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL done_count: got %0d, want %0d", done_cnt - d0, 1); end
        if (mode == 1) begin
            n_cmp++;
            if (stalls != 3) begin n_bad++; $display("FAIL stall_hold: valid held %0d stalled cycles, want 3", stalls); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, array_clear, res_valid, err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b, want 00000", {busy, done, array_clear, res_valid, err});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_row_valid, a_row_idx, b_col_valid, b_col_idx, res_data, res_row, res_col, busy} !== '0) begin
            n_bad++; $display("FAIL reset_data: got av=%b ai=%h bv=%b bi=%h data=%h busy=%b, want all 0",
                              a_row_valid, a_row_idx, b_col_valid, b_col_idx, res_data, busy);
        end
    endtask

    task automatic test_feed();
        logic [R-1:0] ev; logic [R*2-1:0] ei; logic [C-1:0] eb; logic [C*2-1:0] ebi;
        for (int r = 0; r < R; r++) for (int k = 0; k < VL; k++) am[r][k] = 16'((r * VL + k + 1) * 2048);
        for (int k = 0; k < VL; k++) begin bm[k][0] = 16'sd2048; bm[k][1] = (k % 2 == 0) ? 16'sd2048 : 16'sd0; end
        q.push_back('{0, 0, 16'd1280}); q.push_back('{0, 1, 16'd512});
        q.push_back('{1, 0, 16'd3328}); q.push_back('{1, 1, 16'd1536});
        pulse_start();
        n_cmp++;
        if ({array_clear, busy, a_row_valid, b_col_valid} !== {2'b11, 4'b0}) begin
            n_bad++; $display("FAIL clear_cycle: clear=%b busy=%b av=%b bv=%b, want 1 1 00 00", array_clear, busy, a_row_valid, b_col_valid);
        end
        for (int t = 0; t <= FEED_N; t++) begin
            @(negedge clk);
            ev = '0; ei = '0; eb = '0; ebi = '0;
            for (int r = 0; r < R; r++) if (t < FEED_N && t >= r && t < r + VL) begin ev[r] = 1'b1; ei[r*2 +: 2] = 2'(t - r); end
            for (int c = 0; c < C; c++) if (t < FEED_N && t >= c && t < c + VL) begin eb[c] = 1'b1; ebi[c*2 +: 2] = 2'(t - c); end
            n_cmp++;
            if ({a_row_valid, a_row_idx, b_col_valid, b_col_idx, array_clear, busy} !== {ev, ei, eb, ebi, 2'b01}) begin
                n_bad++;
                $display("FAIL feed t=%0d: av=%b ai=%h bv=%b bi=%h clr=%b busy=%b, want av=%b ai=%h bv=%b bi=%h clr=0 busy=1",
                         t, a_row_valid, a_row_idx, b_col_valid, b_col_idx, array_clear, busy, ev, ei, eb, ebi);
            end
        end
        test_drain(0, 1'b0);
    endtask

    task automatic test_stall();
        load_random();
        push_expected();
        pulse_start();
        test_drain(1, 1'b0);
    endtask

    task automatic test_reset_mid_feed();
        load_random();
        push_expected();
        pulse_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        n_cmp++;
        if ({busy, done, array_clear, res_valid, err, a_row_valid, a_row_idx, b_col_valid, b_col_idx, res_data, res_row, res_col} !== '0) begin
            n_bad++; $display("FAIL mid_feed_reset: busy=%b clr=%b av=%b ai=%h bv=%b bi=%h, want all 0",
                              busy, array_clear, a_row_valid, a_row_idx, b_col_valid, b_col_idx);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, a_row_valid} !== 3'b0) begin n_bad++; $display("FAIL idle_after_reset: busy=%b av=%b, want 0 00", busy, a_row_valid); end
        load_random();
        push_expected();
        pulse_start();
        test_drain(0, 1'b0);
    endtask

    task automatic test_ignore_start();
        int d0;
        d0 = done_cnt;
        load_random();
        push_expected();
        pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_cmp++;
        if ({array_clear, busy, a_row_valid} !== 4'b0111) begin
            n_bad++; $display("FAIL start_in_feed: clr=%b busy=%b av=%b, want 0 1 11", array_clear, busy, a_row_valid);
        end
        test_drain(0, 1'b1);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL one_done_per_start: dones=%0d busy=%b, want 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_watchdog();
        bit saw;
        saw = 1'b0;
        load_random();
        vmask = 4'b0111;
`ifdef SYSTOLIC_CTRL_WATCHDOG_EN
        begin
            int n;
            n = 0;
            pulse_start();
            repeat (FEED_N) @(negedge clk);
            while (n < 200) begin
                @(negedge clk);
                if (res_valid) saw = 1'b1;
                if (done) break;
                n++;
            end
            n_cmp++;
            if (n != TO || err !== 1'b1 || saw) begin
                n_bad++; $display("FAIL watchdog: wait=%0d err=%b res_valid_seen=%b, want %0d 1 0", n, err, saw, TO);
            end
            @(negedge clk);
            n_cmp++;
            if ({busy, err} !== 2'b01) begin n_bad++; $display("FAIL err_sticky: busy=%b err=%b, want 0 1", busy, err); end
            rst = 1'b1;
            @(negedge clk) rst = 1'b0;
            n_cmp++;
            if (err !== 1'b0) begin n_bad++; $display("FAIL err_reset: err=%b, want 0", err); end
            vmask = '1;
        end
`else
        push_expected();
        pulse_start();
        repeat (150) begin
            @(negedge clk);
            if (res_valid || done || err) saw = 1'b1;
        end
        n_cmp++;
        if (saw || busy !== 1'b1) begin
            n_bad++; $display("FAIL wait_forever: activity_seen=%b busy=%b, want 0 1", saw, busy);
        end
        vmask = '1;
        test_drain(0, 1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            load_random();
            push_expected();
            pulse_start();
            test_drain(2, 1'b0);
        end
    endtask

    task automatic test_alignment();
        n_cmp++;
        if (misalign !== 1'b0) begin n_bad++; $display("FAIL pe_alignment: a/b index skew seen=%b, want 0", misalign); end
    endtask

    initial begin
        test_reset();
        test_feed();
        test_stall();
        test_reset_mid_feed();
        test_ignore_start();
        test_watchdog();
        test_back_to_back();
        test_alignment();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end
endmodule
